// File: rtl/riscv_pipeline_monitor.sv
// Pipeline observer: saturating event counters plus a first-word-fall-through
// trace FIFO of taken branches (source PC -> target PC).
module riscv_pipeline_monitor #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter int unsigned STOP_ON_OVF = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         clear,
   input  logic [XLEN-1:0]              pc_ex,
   input  logic                         pcsrc,
   input  logic [XLEN-1:0]              pc_target,
   input  logic [1:0]                   forward_a,
   input  logic [1:0]                   forward_b,
   input  logic                         pipeline_stall,
   output logic [CNT_W-1:0]             cycle_cnt,
   output logic [CNT_W-1:0]             stall_cnt,
   output logic [CNT_W-1:0]             branch_cnt,
   output logic [CNT_W-1:0]             fwd_exmem_cnt,
   output logic [CNT_W-1:0]             fwd_memwb_cnt,
   input  logic                         trace_rd,
   output logic                         trace_valid,
   output logic [XLEN-1:0]              trace_src,
   output logic [XLEN-1:0]              trace_dst,
   output logic [$clog2(TRACE_DEPTH):0] trace_level,
   output logic                         trace_overflow
);

   localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic {RUN, FROZEN} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   src_mem [TRACE_DEPTH];
   logic [XLEN-1:0]   dst_mem [TRACE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              full, push_req, push, pop, ovf_set, cnt_en;
   logic [1:0]        exmem_inc, memwb_inc;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      full      = (trace_level == LVL_W'(TRACE_DEPTH));
      push_req  = enable && pcsrc;
      pop       = trace_rd && trace_valid;
      push      = push_req && (!full || pop);
      ovf_set   = push_req && full && !pop;
      cnt_en    = enable && (state_q == RUN);
      exmem_inc = {1'b0, forward_a == 2'b10} + {1'b0, forward_b == 2'b10};
      memwb_inc = {1'b0, forward_a == 2'b01} + {1'b0, forward_b == 2'b01};
   end

   always_comb begin
      state_d = state_q;
      if (state_q == RUN && ovf_set && STOP_ON_OVF != 0)
         state_d = FROZEN;
   end

   always_ff @(posedge clk) begin
      if (reset || clear)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cycle_cnt     <= '0;
         stall_cnt     <= '0;
         branch_cnt    <= '0;
         fwd_exmem_cnt <= '0;
         fwd_memwb_cnt <= '0;
      end else if (cnt_en) begin
         cycle_cnt     <= sat_add(cycle_cnt, 2'd1);
         stall_cnt     <= sat_add(stall_cnt, {1'b0, pipeline_stall});
         branch_cnt    <= sat_add(branch_cnt, {1'b0, pcsrc});
         fwd_exmem_cnt <= sat_add(fwd_exmem_cnt, exmem_inc);
         fwd_memwb_cnt <= sat_add(fwd_memwb_cnt, memwb_inc);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         trace_level    <= '0;
         trace_overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   trace_level <= trace_level + LVL_W'(1);
            2'b01:   trace_level <= trace_level - LVL_W'(1);
            default: trace_level <= trace_level;
         endcase
         if (ovf_set)
            trace_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset && !clear) begin
         src_mem[wr_ptr] <= pc_ex;
         dst_mem[wr_ptr] <= pc_target;
      end
   end

   assign trace_valid = (trace_level != '0);
   assign trace_src   = src_mem[rd_ptr];
   assign trace_dst   = dst_mem[rd_ptr];

endmodule

// File: tb/tb_riscv_pipeline_monitor.sv
// Directed bench for riscv_pipeline_monitor: three instances (default,
// freeze-on-overflow, 4-bit counters) share one stimulus stream.
module tb_riscv_pipeline_monitor;

   logic        clk = 1'b0;
   logic        reset, enable, clear, pcsrc, pipeline_stall, trace_rd;
   logic [31:0] pc_ex, pc_target;
   logic [1:0]  forward_a, forward_b;

   logic [31:0] d_cycle, d_stall, d_branch, d_exmem, d_memwb, d_src, d_dst;
   logic        d_valid, d_ovf;
   logic [3:0]  d_level;
   logic [31:0] s_cycle, s_stall, s_branch, s_exmem, s_memwb, s_src, s_dst;
   logic        s_valid, s_ovf;
   logic [3:0]  s_level;
   logic [3:0]  w_cycle, w_stall, w_branch, w_exmem, w_memwb;
   logic [31:0] w_src, w_dst;
   logic        w_valid, w_ovf;
   logic [3:0]  w_level;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   riscv_pipeline_monitor #(.XLEN(32), .CNT_W(32), .TRACE_DEPTH(8), .STOP_ON_OVF(0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pc_ex(pc_ex), .pcsrc(pcsrc),
      .pc_target(pc_target), .forward_a(forward_a), .forward_b(forward_b),
      .pipeline_stall(pipeline_stall), .cycle_cnt(d_cycle), .stall_cnt(d_stall),
      .branch_cnt(d_branch), .fwd_exmem_cnt(d_exmem), .fwd_memwb_cnt(d_memwb),
      .trace_rd(trace_rd), .trace_valid(d_valid), .trace_src(d_src), .trace_dst(d_dst),
      .trace_level(d_level), .trace_overflow(d_ovf));

   riscv_pipeline_monitor #(.XLEN(32), .CNT_W(32), .TRACE_DEPTH(8), .STOP_ON_OVF(1)) dut_stop (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pc_ex(pc_ex), .pcsrc(pcsrc),
      .pc_target(pc_target), .forward_a(forward_a), .forward_b(forward_b),
      .pipeline_stall(pipeline_stall), .cycle_cnt(s_cycle), .stall_cnt(s_stall),
      .branch_cnt(s_branch), .fwd_exmem_cnt(s_exmem), .fwd_memwb_cnt(s_memwb),
      .trace_rd(trace_rd), .trace_valid(s_valid), .trace_src(s_src), .trace_dst(s_dst),
      .trace_level(s_level), .trace_overflow(s_ovf));

   riscv_pipeline_monitor #(.XLEN(32), .CNT_W(4), .TRACE_DEPTH(8), .STOP_ON_OVF(0)) dut_w4 (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pc_ex(pc_ex), .pcsrc(pcsrc),
      .pc_target(pc_target), .forward_a(forward_a), .forward_b(forward_b),
      .pipeline_stall(pipeline_stall), .cycle_cnt(w_cycle), .stall_cnt(w_stall),
      .branch_cnt(w_branch), .fwd_exmem_cnt(w_exmem), .fwd_memwb_cnt(w_memwb),
      .trace_rd(trace_rd), .trace_valid(w_valid), .trace_src(w_src), .trace_dst(w_dst),
      .trace_level(w_level), .trace_overflow(w_ovf));

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      clear = 1'b0; pcsrc = 1'b0; trace_rd = 1'b0; pipeline_stall = 1'b0;
      forward_a = 2'b00; forward_b = 2'b00; pc_ex = '0; pc_target = '0;
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; idle_inputs();
      tick(1);
      n_vec++; if (d_cycle !== 32'd0) begin n_err++; $display("FAIL rst_cycle got %0d exp 0", d_cycle); end
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", d_valid); end
      n_vec++; if (d_level !== 4'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", d_level); end
      n_vec++; if (d_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", d_ovf); end
      reset = 1'b0; enable = 1'b1;
      tick(20);
      n_vec++; if (d_cycle !== 32'd20) begin n_err++; $display("FAIL idle_cycle got %0d exp 20", d_cycle); end
      n_vec++; if (d_stall !== 32'd0 || d_branch !== 32'd0 || d_exmem !== 32'd0 || d_memwb !== 32'd0) begin
         n_err++; $display("FAIL idle_others got %0d/%0d/%0d/%0d exp 0/0/0/0", d_stall, d_branch, d_exmem, d_memwb); end
      n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b exp 0", d_valid); end
      n_vec++; if (w_cycle !== 4'd15) begin n_err++; $display("FAIL w4_sat_cycle got %0d exp 15", w_cycle); end
   endtask

   task automatic test_counters;
      pipeline_stall = 1'b1; tick(3); pipeline_stall = 1'b0;
      forward_a = 2'b10; forward_b = 2'b10; tick(1);
      forward_a = 2'b01; forward_b = 2'b00; tick(2);
      n_vec++; if (d_stall !== 32'd3) begin n_err++; $display("FAIL stall_cnt got %0d exp 3", d_stall); end
      n_vec++; if (d_exmem !== 32'd2) begin n_err++; $display("FAIL fwd_exmem got %0d exp 2", d_exmem); end
      n_vec++; if (d_memwb !== 32'd2) begin n_err++; $display("FAIL fwd_memwb got %0d exp 2", d_memwb); end
      n_vec++; if (d_cycle !== 32'd26) begin n_err++; $display("FAIL cnt_cycle got %0d exp 26", d_cycle); end
      forward_a = 2'b11; forward_b = 2'b11; tick(1);
      n_vec++; if (d_exmem !== 32'd2 || d_memwb !== 32'd2) begin
         n_err++; $display("FAIL fwd_11_none got %0d/%0d exp 2/2", d_exmem, d_memwb); end
      enable = 1'b0; pipeline_stall = 1'b1; forward_a = 2'b10; tick(2);
      n_vec++; if (d_stall !== 32'd3 || d_cycle !== 32'd27 || d_exmem !== 32'd2) begin
         n_err++; $display("FAIL disabled_hold got %0d/%0d/%0d exp 3/27/2", d_stall, d_cycle, d_exmem); end
      enable = 1'b1; idle_inputs();
   endtask

   task automatic test_branch;
      pcsrc = 1'b1; pc_ex = 32'h10; pc_target = 32'h40; tick(1);
      pcsrc = 1'b0;
      n_vec++; if (d_valid !== 1'b1 || d_level !== 4'd1) begin
         n_err++; $display("FAIL br_push got valid %b level %0d exp 1/1", d_valid, d_level); end
      n_vec++; if (d_src !== 32'h10 || d_dst !== 32'h40) begin
         n_err++; $display("FAIL br_head got %h/%h exp 10/40", d_src, d_dst); end
      n_vec++; if (d_branch !== 32'd1) begin n_err++; $display("FAIL br_cnt got %0d exp 1", d_branch); end
      trace_rd = 1'b1; tick(1);
      n_vec++; if (d_valid !== 1'b0 || d_level !== 4'd0) begin
         n_err++; $display("FAIL br_pop got valid %b level %0d exp 0/0", d_valid, d_level); end
      tick(1);
      n_vec++; if (d_level !== 4'd0) begin n_err++; $display("FAIL pop_empty got level %0d exp 0", d_level); end
      pcsrc = 1'b1; pc_ex = 32'h20; pc_target = 32'h80; tick(1);
      pcsrc = 1'b0; trace_rd = 1'b0;
      n_vec++; if (d_level !== 4'd1 || d_src !== 32'h20 || d_dst !== 32'h80) begin
         n_err++; $display("FAIL empty_push_pop got level %0d head %h/%h exp 1 20/80", d_level, d_src, d_dst); end
      trace_rd = 1'b1; tick(1); trace_rd = 1'b0;
   endtask

   task automatic test_overflow;
      do_clear();
      n_vec++; if (d_cycle !== 32'd0 || d_level !== 4'd0) begin
         n_err++; $display("FAIL ovf_clear got %0d/%0d exp 0/0", d_cycle, d_level); end
      for (int i = 0; i < 9; i++) begin
         pcsrc = 1'b1; pc_ex = 32'h100 + 32'(4 * i); pc_target = 32'h200 + 32'(4 * i);
         tick(1);
      end
      idle_inputs();
      n_vec++; if (d_level !== 4'd8 || d_ovf !== 1'b1) begin
         n_err++; $display("FAIL ovf_state got level %0d ovf %b exp 8/1", d_level, d_ovf); end
      n_vec++; if (d_src !== 32'h100 || d_dst !== 32'h200) begin
         n_err++; $display("FAIL ovf_head got %h/%h exp 100/200", d_src, d_dst); end
      n_vec++; if (s_cycle !== 32'd9 || s_ovf !== 1'b1) begin
         n_err++; $display("FAIL stop_at_ovf got %0d ovf %b exp 9/1", s_cycle, s_ovf); end
      tick(3);
      n_vec++; if (s_cycle !== 32'd9) begin n_err++; $display("FAIL stop_frozen got %0d exp 9", s_cycle); end
      n_vec++; if (d_cycle !== 32'd12) begin n_err++; $display("FAIL nostop_running got %0d exp 12", d_cycle); end
      n_vec++; if (d_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", d_ovf); end
   endtask

   task automatic test_full_push_pop;
      logic [31:0] exp_s, exp_d;
      do_clear();
      n_vec++; if (d_ovf !== 1'b0 || s_ovf !== 1'b0) begin
         n_err++; $display("FAIL clear_ovf got %b/%b exp 0/0", d_ovf, s_ovf); end
      for (int i = 0; i < 8; i++) begin
         pcsrc = 1'b1; pc_ex = 32'h100 + 32'(4 * i); pc_target = 32'h200 + 32'(4 * i);
         tick(1);
      end
      n_vec++; if (d_level !== 4'd8 || d_ovf !== 1'b0) begin
         n_err++; $display("FAIL full_state got level %0d ovf %b exp 8/0", d_level, d_ovf); end
      pc_ex = 32'h300; pc_target = 32'h400; trace_rd = 1'b1; tick(1);
      idle_inputs();
      n_vec++; if (d_level !== 4'd8 || d_ovf !== 1'b0) begin
         n_err++; $display("FAIL full_push_pop got level %0d ovf %b exp 8/0", d_level, d_ovf); end
      n_vec++; if (s_cycle !== 32'd9) begin n_err++; $display("FAIL unfreeze_cycle got %0d exp 9", s_cycle); end
      for (int k = 1; k <= 8; k++) begin
         exp_s = (k < 8) ? 32'h100 + 32'(4 * k) : 32'h300;
         exp_d = (k < 8) ? 32'h200 + 32'(4 * k) : 32'h400;
         n_vec++; if (d_src !== exp_s || d_dst !== exp_d) begin
            n_err++; $display("FAIL drain_%0d got %h/%h exp %h/%h", k, d_src, d_dst, exp_s, exp_d); end
         trace_rd = 1'b1; tick(1);
      end
      trace_rd = 1'b0;
      n_vec++; if (d_level !== 4'd0 || d_valid !== 1'b0) begin
         n_err++; $display("FAIL drained got level %0d valid %b exp 0/0", d_level, d_valid); end
   endtask

   task automatic test_clear_stream;
      for (int i = 0; i < 3; i++) begin
         pcsrc = 1'b1; pipeline_stall = 1'b1; forward_a = 2'b10;
         pc_ex = 32'h500 + 32'(4 * i); pc_target = 32'h600;
         tick(1);
      end
      n_vec++; if (d_level !== 4'd3) begin n_err++; $display("FAIL stream_level got %0d exp 3", d_level); end
      clear = 1'b1; trace_rd = 1'b1; tick(1);
      idle_inputs();
      n_vec++; if (d_cycle !== 32'd0 || d_stall !== 32'd0 || d_branch !== 32'd0 || d_exmem !== 32'd0) begin
         n_err++; $display("FAIL clr_cnt got %0d/%0d/%0d/%0d exp 0/0/0/0", d_cycle, d_stall, d_branch, d_exmem); end
      n_vec++; if (d_level !== 4'd0 || d_valid !== 1'b0 || d_ovf !== 1'b0) begin
         n_err++; $display("FAIL clr_fifo got %0d/%b/%b exp 0/0/0", d_level, d_valid, d_ovf); end
   endtask

   task automatic test_saturation;
      do_clear();
      forward_a = 2'b10; forward_b = 2'b10; tick(7);
      n_vec++; if (w_exmem !== 4'd14) begin n_err++; $display("FAIL w4_exmem7 got %0d exp 14", w_exmem); end
      tick(1);
      n_vec++; if (w_exmem !== 4'd15) begin n_err++; $display("FAIL w4_exmem_sat got %0d exp 15", w_exmem); end
      n_vec++; if (d_exmem !== 32'd16) begin n_err++; $display("FAIL wide_exmem got %0d exp 16", d_exmem); end
      idle_inputs(); tick(12);
      n_vec++; if (w_cycle !== 4'd15) begin n_err++; $display("FAIL w4_cycle20 got %0d exp 15", w_cycle); end
      n_vec++; if (d_cycle !== 32'd20) begin n_err++; $display("FAIL wide_cycle20 got %0d exp 20", d_cycle); end
      n_vec++; if (w_exmem !== 4'd15) begin n_err++; $display("FAIL w4_exmem_hold got %0d exp 15", w_exmem); end
   endtask

   initial begin
      test_reset();
      test_counters();
      test_branch();
      test_overflow();
      test_full_push_pop();
      test_clear_stream();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
